// File: rtl/hyperbus_init_seq.sv
// HyperRAM power-up wait and configuration-register sequencer.
// Holds the system memory request channel closed until the device is configured.
module hyperbus_init_seq #(
  parameter int unsigned PowerupCycles = 120000,
  parameter int unsigned NumItvs       = 5,
  parameter logic [31:0] CfgRegAddr    = 32'h0000_0800,
  parameter logic [15:0] CfgRegData    = 16'h8F1F,
  parameter int unsigned RspTimeout    = 1024,
  parameter int unsigned MaxRetries    = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             en_i,
  output logic                             cfg_req_o,
  output logic [31:0]                      cfg_addr_o,
  output logic [15:0]                      cfg_wdata_o,
  input  logic                             cfg_gnt_i,
  input  logic                             cfg_rsp_valid_i,
  input  logic                             cfg_rsp_err_i,
  output logic                             busy_o,
  output logic                             itv_pulse_o,
  output logic [$clog2(NumItvs+1)-1:0]     itv_idx_o,
  output logic                             ready_o,
  output logic                             error_o,
  input  logic                             mem_req_valid_i,
  output logic                             mem_req_ready_o,
  output logic                             mem_req_valid_o,
  input  logic                             mem_req_ready_i
);

  localparam int unsigned PW = (PowerupCycles > 1) ? $clog2(PowerupCycles) : 1;
  localparam int unsigned TW = (RspTimeout > 1) ? $clog2(RspTimeout) : 1;
  localparam int unsigned RW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
  localparam int unsigned IW = $clog2(NumItvs + 1);
  localparam int unsigned ItvLen = PowerupCycles / NumItvs;

  localparam logic [PW-1:0] PcLast  = PW'(PowerupCycles - 1);
  localparam logic [PW-1:0] IcLast  = PW'(ItvLen - 1);
  localparam logic [TW-1:0] TcLast  = TW'(RspTimeout - 1);
  localparam logic [RW-1:0] RcMax   = RW'(MaxRetries);
  localparam logic [IW-1:0] IdxLast = IW'(NumItvs - 1);

  typedef enum logic [2:0] {
    IDLE, POWERUP, CFG_REQ, CFG_WAIT, READY, ERROR
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_pcnt;
  logic [PW-1:0] r_icnt;
  logic [TW-1:0] r_tcnt;
  logic [RW-1:0] r_rcnt;
  logic [IW-1:0] r_idx;
  logic          r_ready;
  logic          r_error;
  logic          w_pulse;
  logic          w_ok;
  logic          w_fail;

  // r_icnt restarts at every boundary; the last interval just runs to PcLast
  assign w_pulse = (r_state == POWERUP) &&
                   ((r_pcnt == PcLast) ||
                    ((r_icnt == IcLast) && (r_idx < IdxLast)));

  // a response in the timeout cycle wins over the timeout
  assign w_ok   = (r_state == CFG_WAIT) && cfg_rsp_valid_i && !cfg_rsp_err_i;
  assign w_fail = (r_state == CFG_WAIT) &&
                  (cfg_rsp_valid_i ? cfg_rsp_err_i : (r_tcnt == TcLast));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_pcnt  <= '0;
      r_icnt  <= '0;
      r_tcnt  <= '0;
      r_rcnt  <= '0;
      r_idx   <= '0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (en_i) begin
            r_state <= POWERUP;
            r_pcnt  <= '0;
            r_icnt  <= '0;
            r_idx   <= '0;
          end
        end
        POWERUP: begin
          r_icnt <= w_pulse ? '0 : r_icnt + PW'(1);
          if (w_pulse) r_idx <= r_idx + IW'(1);
          if (r_pcnt == PcLast) r_state <= CFG_REQ;
          else                  r_pcnt  <= r_pcnt + PW'(1);
        end
        CFG_REQ: begin
          if (cfg_gnt_i) begin
            r_state <= CFG_WAIT;
            r_tcnt  <= '0;
          end
        end
        CFG_WAIT: begin
          if (w_ok) begin
            r_state <= READY;
            r_ready <= 1'b1;
          end else if (w_fail) begin
            if (r_rcnt < RcMax) begin
              r_rcnt  <= r_rcnt + RW'(1);
              r_state <= CFG_REQ;
            end else begin
              r_state <= ERROR;
              r_error <= 1'b1;
            end
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cfg_req_o   = (r_state == CFG_REQ);
  assign cfg_addr_o  = CfgRegAddr;
  assign cfg_wdata_o = CfgRegData;
  assign busy_o      = (r_state == POWERUP) || (r_state == CFG_REQ) ||
                       (r_state == CFG_WAIT);
  assign itv_pulse_o = w_pulse;
  assign itv_idx_o   = r_idx;
  assign ready_o     = r_ready;
  assign error_o     = r_error;

  assign mem_req_valid_o = mem_req_valid_i & r_ready;
  assign mem_req_ready_o = mem_req_ready_i & r_ready;

endmodule

// File: tb/tb_hyperbus_init_seq.sv
// Bench for hyperbus_init_seq: event scoreboard plus per-cycle level checks
// against a timeline model derived from the power-up and config rules.
module tb_hyperbus_init_seq;

  localparam int P  = 20;
  localparam int N  = 5;
  localparam int TO = 8;
  localparam int MR = 2;
  localparam int P2 = 23;
  localparam int R  = 128;
  localparam int NSCEN = 30;

  logic clk_i = 1'b0;
  logic rst_i, en_i, gnt, rv, re, mvi, mri;
  logic req, busy, pulse, rdy, err, mvo, mro;
  logic [31:0] addr;
  logic [15:0] wdata;
  logic [2:0]  idx;
  logic req2, busy2, pulse2, rdy2, err2, mvo2, mro2;
  logic [31:0] addr2;
  logic [15:0] wdata2;
  logic [2:0]  idx2;

  always #5 clk_i = ~clk_i;

  hyperbus_init_seq #(
    .PowerupCycles(P), .NumItvs(N), .RspTimeout(TO), .MaxRetries(MR)
  ) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .cfg_req_o(req), .cfg_addr_o(addr), .cfg_wdata_o(wdata),
    .cfg_gnt_i(gnt), .cfg_rsp_valid_i(rv), .cfg_rsp_err_i(re),
    .busy_o(busy), .itv_pulse_o(pulse), .itv_idx_o(idx),
    .ready_o(rdy), .error_o(err),
    .mem_req_valid_i(mvi), .mem_req_ready_o(mro),
    .mem_req_valid_o(mvo), .mem_req_ready_i(mri)
  );

  hyperbus_init_seq #(
    .PowerupCycles(P2), .NumItvs(N), .RspTimeout(TO), .MaxRetries(MR)
  ) u_rem (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .cfg_req_o(req2), .cfg_addr_o(addr2), .cfg_wdata_o(wdata2),
    .cfg_gnt_i(1'b0), .cfg_rsp_valid_i(1'b0), .cfg_rsp_err_i(1'b0),
    .busy_o(busy2), .itv_pulse_o(pulse2), .itv_idx_o(idx2),
    .ready_o(rdy2), .error_o(err2),
    .mem_req_valid_i(mvi), .mem_req_ready_o(mro2),
    .mem_req_valid_o(mvo2), .mem_req_ready_i(mri)
  );

  typedef struct {
    int dut;
    int rel;
    int kind;
    int val;
  } ev_t;

  ev_t sb[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  c0 = 0;
  int  ab_lim = R;
  bit  mon_on = 1'b0;

  bit e_req[R], e_busy[R], e_rdy[R], e_err[R];
  int e_idx[R];
  bit d_gnt[R], d_rv[R], d_re[R];

  int a_gd[MR+1], a_out[MR+1], a_t[MR+1];
  bit a_spur[MR+1], a_spe[MR+1];
  int en_len;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc %0d: got %0d expected %0d",
               name, cyc - c0, act, exp);
    end
  endtask

  task automatic push(input int d, input int rel, input int kind, input int val);
    ev_t e;
    if (rel < ab_lim) begin
      e.dut = d; e.rel = rel; e.kind = kind; e.val = val;
      sb.push_back(e);
    end
  endtask

  task automatic observe(input int d, input int kind, input int val, input int rel);
    int f;
    ev_t e;
    f = -1;
    for (int i = 0; i < sb.size() && f < 0; i++)
      if (sb[i].dut == d) f = i;
    tests++;
    if (f < 0) begin
      fails++;
      $display("FAIL sb_unexpected dut%0d kind %0d val %0d at rel %0d",
               d, kind, val, rel);
    end else begin
      e = sb[f];
      sb.delete(f);
      if (e.rel != rel || e.kind != kind || e.val != val) begin
        fails++;
        $display("FAIL sb_event dut%0d: got kind %0d val %0d rel %0d expected kind %0d val %0d rel %0d",
                 d, kind, val, rel, e.kind, e.val, e.rel);
      end
    end
  endtask

  // Timeline model: interval boundaries from plain division, attempts
  // laid out back to back from the planned grant/response delays.
  task automatic plan(input int abort, output int last);
    int L, L2, t, q, w0, fin, term, cnt, pr;
    bit done;
    for (int r = 0; r < R; r++) begin
      e_req[r] = 0; e_busy[r] = 0; e_rdy[r] = 0; e_err[r] = 0;
      d_gnt[r] = 0; d_rv[r] = 0; d_re[r] = 0;
    end
    ab_lim = (abort > 0) ? abort : R;
    L  = P / N;
    L2 = P2 / N;
    for (int k = 1; k <= N; k++) push(0, (k == N) ? P : k * L, 0, k - 1);
    for (int k = 1; k <= N; k++) push(1, (k == N) ? P2 : k * L2, 0, k - 1);
    push(1, P2 + 1, 1, 0);
    for (int r = 0; r < R; r++) begin
      cnt = 0;
      for (int k = 1; k <= N; k++) begin
        pr = (k == N) ? P : k * L;
        if (pr < r) cnt++;
      end
      e_idx[r] = cnt;
    end
    t = P + 1;
    term = R;
    done = 0;
    for (int a = 0; a <= MR; a++) begin
      if (!done) begin
        q = t;
        push(0, q, 1, 0);
        for (int r = q; r <= q + a_gd[a]; r++) e_req[r] = 1;
        d_gnt[q + a_gd[a]] = 1;
        w0 = q + a_gd[a] + 1;
        if (a_spur[a] && a_gd[a] > 0) begin
          d_rv[q] = 1;
          d_re[q] = a_spe[a];
        end
        if (a_out[a] == 2) fin = w0 + TO - 1;
        else begin
          fin = w0 + a_t[a];
          d_rv[fin] = 1;
          d_re[fin] = (a_out[a] == 1);
        end
        if (a_out[a] == 0) begin
          term = fin + 1;
          for (int r = term; r < R; r++) e_rdy[r] = 1;
          done = 1;
        end else if (a == MR) begin
          term = fin + 1;
          for (int r = term; r < R; r++) e_err[r] = 1;
          done = 1;
        end else begin
          t = fin + 1;
        end
      end
    end
    for (int r = 1; r < term && r < R; r++) e_busy[r] = 1;
    last = (term + 2 > P2 + 3) ? term + 2 : P2 + 3;
    if (abort > 0) begin
      for (int r = abort; r < R; r++) begin
        e_req[r] = 0; e_busy[r] = 0; e_rdy[r] = 0; e_err[r] = 0; e_idx[r] = 0;
      end
      last = abort + 3;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   int'(req),   0);
    chk({tag, "_busy"},  int'(busy),  0);
    chk({tag, "_pulse"}, int'(pulse), 0);
    chk({tag, "_idx"},   int'(idx),   0);
    chk({tag, "_ready"}, int'(rdy),   0);
    chk({tag, "_error"}, int'(err),   0);
    chk({tag, "_mvo"},   int'(mvo),   0);
    chk({tag, "_mro"},   int'(mro),   0);
    chk({tag, "_addr"},  int'(addr),  32'h800);
    chk({tag, "_wdata"}, int'(wdata), 16'h8F1F);
    chk({tag, "_idx2"},  int'(idx2),  0);
  endtask

  // Monitor: level checks every cycle, events pushed to the scoreboard
  initial begin
    bit p_req, p_req2;
    int rel;
    p_req = 0;
    p_req2 = 0;
    forever begin
      @(negedge clk_i);
      rel = cyc - c0;
      if (mon_on && rel >= 0 && rel < R) begin
        chk("cfg_req", int'(req),  int'(e_req[rel]));
        chk("busy",    int'(busy), int'(e_busy[rel]));
        chk("ready",   int'(rdy),  int'(e_rdy[rel]));
        chk("error",   int'(err),  int'(e_err[rel]));
        chk("itv_idx", int'(idx),  e_idx[rel]);
        chk("gate_v",  int'(mvo),  int'(mvi & e_rdy[rel]));
        chk("gate_r",  int'(mro),  int'(mri & e_rdy[rel]));
        if (pulse) observe(0, 0, int'(idx), rel);
        if (pulse2) observe(1, 0, int'(idx2), rel);
        if (req && !p_req) begin
          observe(0, 1, 0, rel);
          chk("cfg_addr",  int'(addr),  32'h800);
          chk("cfg_wdata", int'(wdata), 16'h8F1F);
        end
        if (req2 && !p_req2) observe(1, 1, 0, rel);
      end
      p_req = req;
      p_req2 = req2;
    end
  end

  task automatic run_scen(input int abort);
    int last;
    @(posedge clk_i); #1;
    mon_on = 0;
    rst_i = 1; en_i = 0; gnt = 0; rv = 0; re = 0; mvi = 1; mri = 1;
    #1;
    chk_reset("rst");
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 0;
    repeat ($urandom_range(0, 3)) @(posedge clk_i);
    @(posedge clk_i); #1;
    c0 = cyc;
    plan(abort, last);
    mon_on = 1;
    for (int rel = 0; rel <= last; rel++) begin
      if (rel > 0) begin
        @(posedge clk_i); #1;
      end
      en_i = (rel < en_len);
      gnt  = d_gnt[rel];
      rv   = d_rv[rel];
      re   = rv ? d_re[rel] : 1'($urandom_range(0, 1));
      mvi  = 1'($urandom_range(0, 1));
      mri  = 1'($urandom_range(0, 1));
      if (abort > 0 && rel == abort) begin
        rst_i = 1;
        #1;
        chk_reset("abort");
      end
    end
    @(posedge clk_i); #1;
    mon_on = 0;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_missing: got %0d leftover events expected 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic set_att(input int a, input int gd, input int out, input int t);
    a_gd[a] = gd; a_out[a] = out; a_t[a] = t; a_spur[a] = 0; a_spe[a] = 0;
  endtask

  initial begin
    int abort;
    rst_i = 1; en_i = 0; gnt = 0; rv = 0; re = 0; mvi = 0; mri = 0;
    for (int s = 0; s < NSCEN; s++) begin
      abort = 0;
      en_len = 1;
      for (int a = 0; a <= MR; a++) set_att(a, 0, 2, 0);
      unique case (s)
        0, 3, 4: set_att(0, 0, 0, 2);
        1: begin
          set_att(0, 0, 1, 1);
          set_att(1, 0, 0, 2);
        end
        2: en_len = 3;
        default: begin
          en_len = $urandom_range(1, 40);
          for (int a = 0; a <= MR; a++) begin
            a_gd[a]   = $urandom_range(0, 3);
            a_out[a]  = $urandom_range(0, 3);
            if (a_out[a] == 3) a_out[a] = 0;
            a_t[a]    = $urandom_range(0, TO - 1);
            a_spur[a] = 1'($urandom_range(0, 1));
            a_spe[a]  = 1'($urandom_range(0, 1));
          end
          if ($urandom_range(0, 5) == 0) abort = $urandom_range(2, 40);
        end
      endcase
      if (s == 3) abort = 10;
      run_scen(abort);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hyperbus_init_seq.md
# hyperbus_init_seq

Power-up and configuration sequencer for the HyperRAM subsystem. It enforces the HyperRAM power-up wait in hardware instead of relying on the bench delay. The wait is split into reporting intervals. After the wait, it writes the configuration register through a request/grant/response port on the HyperBus controller. It then opens a gate on the system memory request channel. Requests never reach the HyperBus before the device is powered and configured.

## Interface
- PowerupCycles, 120000, length of power-up wait in clk cycles (600 us at 200 MHz); must be ≥ NumItvs
- NumItvs, 5, number of progress intervals; must be ≥ 1
- CfgRegAddr, 32'h0000_0800, address driven on cfg_addr_o
- CfgRegData, 16'h8F1F, data driven on cfg_wdata_o
- RspTimeout, 1024, cycles to wait for a config response after grant
- MaxRetries, 3, extra config attempts after the first (total attempts MaxRetries+1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- en_i  in  1  start request, sampled only in IDLE
- cfg_req_o  out  1  config write request
- cfg_addr_o  out  32  constant CfgRegAddr
- cfg_wdata_o  out  16  constant CfgRegData
- cfg_gnt_i  in  1  controller accepts the request
- cfg_rsp_valid_i  in  1  config write response
- cfg_rsp_err_i  in  1  response carries error, qualified by cfg_rsp_valid_i
- busy_o  out  1  state ∉ {IDLE, READY, ERROR}
- itv_pulse_o  out  1  last cycle of each power-up interval
- itv_idx_o  out  $clog2(NumItvs+1)  completed interval count
- ready_o  out  1  init done, gate open
- error_o  out  1  init failed, sticky
- mem_req_valid_i / mem_req_ready_o  in/out  1  upstream channel
- mem_req_valid_o / mem_req_ready_i  out/in  1  downstream channel

## Operation
- FSM states: IDLE, POWERUP, CFG_REQ, CFG_WAIT, READY, ERROR.
- IDLE → POWERUP on en_i=1. The power-up counter pcnt is cleared to 0 on entry.
- POWERUP: pcnt increments every cycle.
  - ItvLen = PowerupCycles / NumItvs (floor). The last interval absorbs the remainder.
  - itv_pulse_o = 1 when pcnt == k·ItvLen−1 for k = 1..NumItvs−1, and when pcnt == PowerupCycles−1.
  - At pcnt == PowerupCycles−1 the FSM moves to CFG_REQ. POWERUP therefore lasts exactly PowerupCycles cycles.
- itv_idx_o is registered. It increments in the cycle after each itv_pulse_o and holds NumItvs after power-up.
- CFG_REQ: cfg_req_o = 1 until cfg_gnt_i.
  - Grant in the same cycle → CFG_WAIT, with timeout counter tcnt cleared.
  - There is no timeout in CFG_REQ.
  - cfg_rsp_valid_i is ignored in CFG_REQ.
- CFG_WAIT: cfg_req_o = 0 and tcnt increments each cycle.
  - rsp_valid with no error → READY.
  - rsp_valid with error, or tcnt reaching RspTimeout−1 without a response, is a failed attempt. On a failed attempt rcnt increments. If rcnt < MaxRetries → CFG_REQ; otherwise → ERROR.
  - A response arriving in the timeout cycle takes priority over the timeout.
- READY and ERROR are terminal until reset. en_i is ignored outside IDLE, and deasserting it mid-sequence does not abort.
- Gate:
  - mem_req_valid_o = mem_req_valid_i & ready_o
  - mem_req_ready_o = mem_req_ready_i & ready_o
  - The gate is combinational, with no added latency once open.
  - In ERROR the gate stays closed.

## Timing
- Reset values: state IDLE, all counters 0, cfg_req_o=0, busy_o=0, itv_pulse_o=0, itv_idx_o=0, ready_o=0, error_o=0.
  - The gate is closed in reset; cfg_addr_o and cfg_wdata_o carry their constants.
- Reset asserted mid-sequence returns everything to reset values asynchronously. Any outstanding config transaction is abandoned.
- Latency:
  - en_i high at cycle 0 → POWERUP at cycle 1.
  - cfg_req_o rises at cycle PowerupCycles+1.
  - With grant at cycle g and response at r > g, ready_o rises at r+1.
- ready_o and error_o are registered from the state. They are never high together.
- busy_o, itv_pulse_o and cfg_req_o are decoded from the state/counter with no extra delay.
- Counter widths:
  - pcnt: $clog2(PowerupCycles)
  - tcnt: $clog2(RspTimeout)
  - rcnt: $clog2(MaxRetries+1)
  - No counter wraps inside its state.

## Test plan
All scenarios use PowerupCycles=20, NumItvs=5, RspTimeout=8, MaxRetries=2.
- Nominal: en_i pulse at cycle 0.
  - itv_pulse_o at cycles 4, 8, 12, 16, 20; itv_idx_o reads 5 from cycle 21.
  - cfg_req_o high at cycle 21 with addr 0x800 and data 0x8F1F.
  - Grant at 21, clean response at 24 → ready_o = 1 at 25.
- Remainder: PowerupCycles=23 → pulses at cycles 4, 8, 12, 16, 23; cfg_req_o at 24.
- Error retry: first response has err=1, second is clean → cfg_req_o is reasserted the cycle after the err response and ready_o follows the clean response. rcnt=1.
- Timeout exhaustion: grant given on every attempt, no response ever → 3 attempts of 8 CFG_WAIT cycles each, then error_o = 1. ready_o stays 0 and mem_req_valid_o stays 0 while mem_req_valid_i = 1.
- Gate: before READY, mem_req_valid_i = 1 gives valid_o = 0 and ready_o = 0. After READY, valid/ready pass through in the same cycle.
- Reset mid-operation: rst_i asserted at cycle 10 of POWERUP → all outputs at reset values immediately. A new en_i restarts with the full 20-cycle wait and itv_idx_o back at 0.
